// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: main road rests green, side requests are
// served through yellow and all-red clearance. Define PED_WALK_EN for the walk phase.
module intersection_controller #(
  parameter int MIN_GREEN  = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int CLEAR      = 2,
  parameter int WALK       = 5,
  parameter int TW         = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_CLEAR_A     = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_CLEAR_B     = 3'd5,
    ST_PED_WALK    = 3'd6
  } state_t;

  localparam logic [0:2] RED = 3'b100;
  localparam logic [0:2] GRN = 3'b010;
  localparam logic [0:2] YEL = 3'b001;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q;
  logic [0:2]    main_q, main_d;
  logic [0:2]    side_q, side_d;
  logic          walk_q, walk_d;
  logic          done;

  function automatic logic [TW-1:0] dwell(input state_t s);
    case (s)
      ST_MAIN_GREEN:  dwell = TW'(MIN_GREEN - 1);
      ST_MAIN_YELLOW: dwell = TW'(YELLOW - 1);
      ST_SIDE_GREEN:  dwell = TW'(SIDE_GREEN - 1);
      ST_SIDE_YELLOW: dwell = TW'(YELLOW - 1);
      ST_PED_WALK:    dwell = TW'(WALK - 1);
      default:        dwell = TW'(CLEAR - 1);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    done    = (timer_q == '0);
    timer_d = done ? '0 : timer_q - 1'b1;
    case (state_q)
      ST_MAIN_GREEN:
        if (done && (side_pend_q || ped_pend_q)) state_d = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW:
        if (done) state_d = ST_CLEAR_A;
      ST_CLEAR_A:
        if (done) begin
          if (side_pend_q)     state_d = ST_SIDE_GREEN;
          else if (ped_pend_q) state_d = ST_PED_WALK;
          else                 state_d = ST_MAIN_GREEN;
        end
      ST_SIDE_GREEN:
        if (done) state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW:
        if (done) state_d = ST_CLEAR_B;
      ST_CLEAR_B:
        if (done) state_d = ped_pend_q ? ST_PED_WALK : ST_MAIN_GREEN;
`ifdef PED_WALK_EN
      ST_PED_WALK:
        if (done) state_d = ST_MAIN_GREEN;
`endif
      default:
        state_d = ST_CLEAR_B;
    endcase
    if (state_d != state_q) timer_d = dwell(state_d);

    // entering side green wins over a request on the same edge
    side_pend_d = side_pend_q | (side_req && state_q != ST_SIDE_GREEN);
    if (state_d == ST_SIDE_GREEN && state_q != ST_SIDE_GREEN)
      side_pend_d = 1'b0;

    main_d = RED;
    side_d = RED;
    walk_d = 1'b0;
    case (state_d)
      ST_MAIN_GREEN:  main_d = GRN;
      ST_MAIN_YELLOW: main_d = YEL;
      ST_SIDE_GREEN:  side_d = GRN;
      ST_SIDE_YELLOW: side_d = YEL;
`ifdef PED_WALK_EN
      ST_PED_WALK:    walk_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR_B;
      timer_q     <= TW'(CLEAR - 1);
      side_pend_q <= 1'b0;
      main_q      <= RED;
      side_q      <= RED;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_q      <= walk_d;
    end
  end

`ifdef PED_WALK_EN
  logic ped_pend_d;

  always_comb begin
    ped_pend_d = ped_pend_q | (ped_req && state_q != ST_PED_WALK);
    if (state_d == ST_PED_WALK && state_q != ST_PED_WALK)
      ped_pend_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) ped_pend_q <= 1'b0;
    else          ped_pend_q <= ped_pend_d;
  end
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_pend_q = 1'b0;
`endif

  assign main_light = main_q;
  assign side_light = side_q;
  assign walk       = walk_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: vector table, corner sequences and a
// randomized run against a phase/age reference model.
module tb_intersection_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       walk;
  logic [2:0] phase;

  int n_pass = 0;
  int n_tot  = 0;

  intersection_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rn;
    logic s;
    logic p;
    int   ph;
  } vec_t;

  vec_t tbl[$];

  int   m_ph;
  int   m_age;
  logic m_sp;
  logic m_pp;

  function automatic logic [9:0] expv(input int ph);
    logic [0:2] m;
    logic [0:2] sd;
    m  = 3'b100;
    sd = 3'b100;
    case (ph)
      0: m  = 3'b010;
      1: m  = 3'b001;
      3: sd = 3'b010;
      4: sd = 3'b001;
      default: ;
    endcase
    return {3'(ph), m, sd, ph == 6};
  endfunction

  function automatic logic [9:0] got();
    return {phase, main_light, side_light, walk};
  endfunction

  task automatic chk(input string nm, input logic [9:0] g, input logic [9:0] e);
    n_tot++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", nm, g, e, $time);
  endtask

  task automatic add(input int n, input logic rn, input logic s,
                     input logic p, input int ph);
    vec_t v;
    v.rn = rn;
    v.s  = s;
    v.p  = p;
    v.ph = ph;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic wait_phase(input int ph, input int lim);
    int k;
    k = 0;
    while (int'(phase) != ph && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk($sformatf("reach_phase%0d", ph), {7'd0, phase}, 10'(ph));
  endtask

  function automatic int dur(input int ph);
    case (ph)
      0: return 8;
      1: return 3;
      2: return 2;
      3: return 6;
      4: return 3;
      5: return 2;
      6: return 5;
      default: return 1;
    endcase
  endfunction

  // Reference: phase plus cycles spent in it; a phase of length N is done
  // once it has been occupied for N cycles.
  task automatic model_step(input logic rn, input logic s, input logic p);
    int   nx;
    logic fin;
    logic sp;
    logic pp;
    if (!rn) begin
      m_ph  = 5;
      m_age = 0;
      m_sp  = 1'b0;
      m_pp  = 1'b0;
      return;
    end
    fin = (m_age + 1 >= dur(m_ph));
    nx  = m_ph;
    if (fin) begin
      case (m_ph)
        0: if (m_sp || m_pp) nx = 1;
        1: nx = 2;
        2: nx = m_sp ? 3 : (m_pp ? 6 : 0);
        3: nx = 4;
        4: nx = 5;
        5: nx = m_pp ? 6 : 0;
        default: nx = 0;
      endcase
    end
    sp = m_sp | (s && m_ph != 3);
    if (nx == 3 && m_ph != 3) sp = 1'b0;
`ifdef PED_WALK_EN
    pp = m_pp | (p && m_ph != 6);
    if (nx == 6 && m_ph != 6) pp = 1'b0;
`else
    pp = 1'b0;
    if (p) pp = 1'b0;
`endif
    m_age = (nx != m_ph) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
    m_ph  = nx;
    m_sp  = sp;
    m_pp  = pp;
  endtask

  initial begin
    logic rn;
    logic s;
    logic p;

    // reset and rest
    add(3, 0, 0, 0, 5);
    add(1, 1, 0, 0, 5);
    add(50, 1, 0, 0, 0);
    // minimum green with an early one-cycle pulse
    add(1, 0, 0, 0, 5);
    add(1, 1, 0, 0, 5);
    add(2, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0);
    add(5, 1, 0, 0, 0);
    add(3, 1, 0, 0, 1);
    add(2, 1, 0, 0, 2);
    add(6, 1, 0, 0, 3);
    add(3, 1, 0, 0, 4);
    add(2, 1, 0, 0, 5);
    add(5, 1, 0, 0, 0);
`ifdef PED_WALK_EN
    add(10, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0);
    add(3, 1, 0, 0, 1);
    add(2, 1, 0, 0, 2);
    add(6, 1, 0, 0, 3);
    add(3, 1, 0, 0, 4);
    add(2, 1, 0, 0, 5);
    add(5, 1, 0, 0, 6);
    add(3, 1, 0, 0, 0);
`else
    add(20, 1, 0, 1, 0);
`endif

    foreach (tbl[i]) begin
      reset_n  = tbl[i].rn;
      side_req = tbl[i].s;
      ped_req  = tbl[i].p;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("vec%0d", i), got(), expv(tbl[i].ph));
    end
    ped_req = 1'b0;

    // late request: yellow two edges after raising, held request not re-armed
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_phase(0, 10);
    repeat (19) @(negedge clock);
    side_req = 1'b1;
    @(negedge clock);
    chk("late_edge1", got(), expv(0));
    @(negedge clock);
    chk("late_edge2", got(), expv(1));
    wait_phase(4, 30);
    side_req = 1'b0;
    wait_phase(0, 20);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk("no_retrigger", got(), expv(0));
    end

    // reset in the third side-green cycle
    side_req = 1'b1;
    @(negedge clock);
    side_req = 1'b0;
    wait_phase(3, 40);
    repeat (2) @(negedge clock);
    chk("side_green_c3", got(), expv(3));
    reset_n  = 1'b0;
    side_req = 1'b1;
    @(negedge clock);
    chk("mid_reset", got(), expv(5));
    reset_n  = 1'b1;
    side_req = 1'b0;
    @(negedge clock);
    chk("mid_reset_clr", got(), expv(5));
    @(negedge clock);
    chk("mid_reset_main", got(), expv(0));
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      chk("pend_cleared", got(), expv(0));
    end

    // randomized run against the reference model
    reset_n  = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    model_step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      chk("rand", got(), expv(m_ph));
      chk("no_conflict",
          {9'd0, (main_light != 3'b100) && (side_light != 3'b100)}, 10'd0);
      chk("no_phase7", {9'd0, phase == 3'd7}, 10'd0);
      rn = ($urandom_range(0, 799) != 0);
      s  = ($urandom_range(0, 11) == 0);
      p  = ($urandom_range(0, 11) == 0);
      reset_n  = rn;
      side_req = s;
      ped_req  = p;
      model_step(rn, s, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
